// File: rtl/led_matrix_sprite_scanner.sv
// ---------------------------------------------------------------------------
// led_matrix_sprite_scanner
//
// Scans a ROWS x COLS LED matrix one row at a time (one-hot row select) and
// renders a 5-wide x 6-tall player sprite on the bottom six rows. The sprite
// is steered by debounced left/right buttons; a function button toggles
// between PLAY (sprite) and TEST (every LED on). Position changes are staged
// in a pending register and only copied to the displayed position at the
// start of row 0, so a frame never shows two different sprite positions.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   left_btn     raw asynchronous button, active-high
//   right_btn    raw asynchronous button, active-high
//   function_btn raw asynchronous button, active-high, toggles mode
//   screen_row   one-hot active row (registered)
//   screen_col   column data for the active row, bit i = column i (registered)
//   human_col    displayed sprite left-column position
//   mode         0 = PLAY, 1 = TEST
//   frame_start  one-cycle pulse in the first cycle of row 0
// ---------------------------------------------------------------------------
module led_matrix_sprite_scanner #(
    parameter int ROWS     = 16,
    parameter int COLS     = 32,
    parameter int DWELL    = 1,
    parameter int MOVE_DIV = 1000,
    parameter int DEB_LEN  = 4,
    parameter int WRAP     = 0,
    parameter int CW       = $clog2(COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            left_btn,
    input  logic            right_btn,
    input  logic            function_btn,
    output logic [ROWS-1:0] screen_row,
    output logic [COLS-1:0] screen_col,
    output logic [CW-1:0]   human_col,
    output logic            mode,
    output logic            frame_start
);

    // -----------------------------------------------------------------------
    // Derived widths and constants
    // -----------------------------------------------------------------------
    localparam int RW = $clog2(ROWS);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int PW = $clog2(MOVE_DIV);
    // The debounce counter only ever holds 0..DEB_LEN-1: reaching DEB_LEN-1
    // with one more disagreeing sample flips the state and clears it.
    localparam int BW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam int NB = 3;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_FUNC  = 2;

    localparam logic [CW-1:0] POS_MAX    = CW'(COLS - 5);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [RW-1:0] SPRITE_TOP = RW'(ROWS - 6);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [PW-1:0] TICK_AT    = PW'(MOVE_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEB_LEN - 1);

    typedef enum logic {
        MODE_PLAY = 1'b0,
        MODE_TEST = 1'b1
    } mode_e;

    // -----------------------------------------------------------------------
    // Button synchronisers and debouncers (one identical slice per button)
    // -----------------------------------------------------------------------
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_deb;

    assign btn_raw[BTN_LEFT]  = left_btn;
    assign btn_raw[BTN_RIGHT] = right_btn;
    assign btn_raw[BTN_FUNC]  = function_btn;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_btn
            logic          sync1_q, sync1_d;
            logic          sync2_q, sync2_d;
            logic          deb_q,   deb_d;
            logic [BW-1:0] cnt_q,   cnt_d;

            always_comb begin
                sync1_d = btn_raw[gi];
                sync2_d = sync1_q;
                deb_d   = deb_q;
                cnt_d   = '0;
                // Any sample agreeing with the debounced state restarts the
                // count; DEB_LEN disagreeing samples in a row flip it.
                if (sync2_q != deb_q) begin
                    if (cnt_q == DEB_LAST) begin
                        deb_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    deb_q   <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    deb_q   <= deb_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign btn_deb[gi] = deb_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [RW-1:0]   row_q,         row_d;
    logic [DW-1:0]   dwell_q,       dwell_d;
    logic [PW-1:0]   pre_q,         pre_d;
    logic [CW-1:0]   pend_q,        pend_d;
    logic [CW-1:0]   human_col_q,   human_col_d;
    logic            fn_prev_q,     fn_prev_d;
    mode_e           mode_q,        mode_d;
    logic [ROWS-1:0] screen_row_q,  screen_row_d;
    logic [COLS-1:0] screen_col_q,  screen_col_d;
    logic            frame_start_q, frame_start_d;

    logic          advance;
    logic          tick;
    logic          go_right;
    logic          go_left;
    logic [RW-1:0] sprite_rel;
    logic [4:0]    sprite_pat;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // Row scan: hold each row for DWELL clocks.
        advance = (dwell_q == DWELL_LAST);
        dwell_d = advance ? '0 : dwell_q + 1'b1;
        row_d   = row_q;
        if (advance) begin
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end
        frame_start_d = advance && (row_q == ROW_LAST);

        // Mode toggles one cycle after a debounced rising edge.
        fn_prev_d = btn_deb[BTN_FUNC];
        mode_d    = mode_q;
        if (btn_deb[BTN_FUNC] && !fn_prev_q) begin
            mode_d = (mode_q == MODE_PLAY) ? MODE_TEST : MODE_PLAY;
        end

        // Movement prescaler.
        tick  = (pre_q == TICK_AT);
        pre_d = tick ? '0 : pre_q + 1'b1;

        // Pending position. Edge tests come before the +/-1 so the CW-bit
        // arithmetic never overflows or underflows.
        go_right = btn_deb[BTN_RIGHT] && !btn_deb[BTN_LEFT];
        go_left  = btn_deb[BTN_LEFT]  && !btn_deb[BTN_RIGHT];
        pend_d   = pend_q;
        if (tick && (mode_q == MODE_PLAY)) begin
            if (go_right) begin
                if (pend_q == POS_MAX) begin
                    pend_d = (WRAP != 0) ? '0 : POS_MAX;
                end else begin
                    pend_d = pend_q + 1'b1;
                end
            end else if (go_left) begin
                if (pend_q == '0) begin
                    pend_d = (WRAP != 0) ? POS_MAX : '0;
                end else begin
                    pend_d = pend_q - 1'b1;
                end
            end
        end

        // Displayed position only changes as row 0 begins. A tick landing on
        // that same edge updates pend_d, which the next frame picks up.
        human_col_d = frame_start_d ? pend_q : human_col_q;

        // Sprite bitmap for the row about to be shown. Bit k of the pattern
        // is column offset k; every row pattern is a palindrome.
        sprite_rel = '0;
        sprite_pat = 5'b00000;
        if (row_d >= SPRITE_TOP) begin
            sprite_rel = row_d - SPRITE_TOP;
            case (sprite_rel)
                RW'(0), RW'(1), RW'(2): sprite_pat = 5'b01110;
                RW'(3):                 sprite_pat = 5'b10101;
                RW'(4):                 sprite_pat = 5'b01110;
                RW'(5):                 sprite_pat = 5'b10001;
                default:                sprite_pat = 5'b00000;
            endcase
        end

        // Row and column are both computed from next-state values so they
        // land in the output registers on the same edge.
        screen_row_d = {{(ROWS-1){1'b0}}, 1'b1} << row_d;
        if (mode_d == MODE_TEST) begin
            screen_col_d = '1;
        end else begin
            screen_col_d = {{(COLS-5){1'b0}}, sprite_pat} << human_col_d;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q         <= '0;
            dwell_q       <= '0;
            pre_q         <= '0;
            pend_q        <= '0;
            human_col_q   <= '0;
            fn_prev_q     <= 1'b0;
            mode_q        <= MODE_PLAY;
            screen_row_q  <= {{(ROWS-1){1'b0}}, 1'b1};
            screen_col_q  <= '0;
            frame_start_q <= 1'b0;
        end else begin
            row_q         <= row_d;
            dwell_q       <= dwell_d;
            pre_q         <= pre_d;
            pend_q        <= pend_d;
            human_col_q   <= human_col_d;
            fn_prev_q     <= fn_prev_d;
            mode_q        <= mode_d;
            screen_row_q  <= screen_row_d;
            screen_col_q  <= screen_col_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign screen_row  = screen_row_q;
    assign screen_col  = screen_col_q;
    assign human_col   = human_col_q;
    assign mode        = mode_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/led_matrix_sprite_scanner.md
Name: led_matrix_sprite_scanner

Overview:
- Parametrised successor to the fixed 16x32 matrix driver: scans a ROWS x COLS LED matrix one row at a time, one-hot.
- Renders a 5-wide x 6-tall player sprite on the bottom six rows; the sprite moves with debounced left/right buttons.
- Adds a function-button mode toggle (PLAY / TEST all-on), clamp-or-wrap edge handling, and tear-free frame-boundary position updates.
- Sits between the board buttons and the matrix row/column drivers.

Parameters:
- ROWS, 16, matrix rows; >= 8.
- COLS, 32, matrix columns; >= 8.
- DWELL, 1, clocks each row stays active; >= 1.
- MOVE_DIV, 1000, clocks per movement tick; >= 2.
- DEB_LEN, 4, consecutive equal synchronised samples needed to change a debounced button state; >= 1.
- WRAP, 0, edge mode: 0 = clamp at edges, 1 = wrap around.
- CW, $clog2(COLS), width of the position field (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- left_btn  in  1  raw asynchronous button, active-high.
- right_btn  in  1  raw asynchronous button, active-high.
- function_btn  in  1  raw asynchronous button, active-high; toggles mode.
- screen_row  out  ROWS  one-hot active row.
- screen_col  out  COLS  column data for the active row; bit i = column i.
- human_col  out  CW  displayed sprite left-column position.
- mode  out  1  0 = PLAY, 1 = TEST.
- frame_start  out  1  one-cycle pulse in the first cycle of row 0.

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values of every output:
  - screen_row = 1 (row 0 active).
  - screen_col = 0.
  - human_col = 0.
  - mode = 0.
  - frame_start = 0.
  - All internal state is cleared: row index, dwell counter, tick prescaler, debounce counters, pending position.
  - Asserting rst mid-frame or mid-debounce gives exactly these values on the next edge. The first frame_start after reset occurs DWELL*ROWS cycles after rst deasserts.
- Scan:
  - Row index r is held for DWELL clocks, then advances; ROWS-1 wraps to 0.
  - screen_row = 1 << r, registered.
  - screen_col is registered in the same cycle as screen_row, so both change together. There is no skew between row and column data.
- Sprite bitmap, offset 0..4 from human_col, listed top to bottom:
  - Rows ROWS-6 .. ROWS-4: 01110.
  - Row ROWS-3: 10101.
  - Row ROWS-2: 01110.
  - Row ROWS-1: 10001.
  - Pattern bit k drives column human_col+k. All other rows and columns are 0.
- Column output by mode: PLAY drives the sprite bitmap; TEST drives all ones on every row.
- Input synchronisation and debounce:
  - Each button passes through a 2-flop synchroniser, then a saturating counter.
  - The debounced state flips only after DEB_LEN consecutive synchronised samples differ from the current debounced state. Any agreeing sample clears the counter.
  - Worst-case latency from a raw edge to a debounced change is 2 + DEB_LEN cycles.
- Mode toggle:
  - A rising edge of debounced function_btn toggles mode in the following cycle.
  - Holding the button produces no further toggles.
- Movement:
  - A prescaler emits a tick every MOVE_DIV clocks, first tick at count MOVE_DIV-1 after reset.
  - Tick in PLAY, right debounced and left not: pending position +1.
  - Tick in PLAY, left debounced and right not: pending position -1.
  - Both buttons or neither: hold.
  - In TEST the pending position is frozen.
  - Limit MAX = COLS-5.
  - WRAP=0: right at MAX holds; left at 0 holds.
  - WRAP=1: right at MAX goes to 0; left at 0 goes to MAX.
- Tear-free update:
  - human_col loads the pending position only in the cycle row 0 begins (the frame_start cycle). Column data for that row already uses the new value.
  - A tick landing in the same cycle as the frame-boundary load applies at the next frame boundary.
- Arithmetic: all position arithmetic is on CW bits. The MAX comparison precedes the increment, so there is no overflow.

Test Plan:
- Reset/scan (ROWS=16, DWELL=2):
  - Stimulus: deassert rst and run the scan.
  - Required: screen_row = 0x0001 for 2 cycles, then 0x0002, ..., then 0x8000, then wraps to 0x0001.
  - Required: frame_start pulses exactly once per 32 cycles.
  - Required: screen_col = 0 on rows 0..9.
- Sprite render (human_col=0, COLS=32):
  - Row 0x0400 gives screen_col = 0x0000000E.
  - Row 0x2000 gives screen_col = 0x00000015.
  - Row 0x8000 gives screen_col = 0x00000011.
- Clamp (WRAP=0, MOVE_DIV=8, DEB_LEN=3):
  - Stimulus: hold right_btn for 40 ticks.
  - Required: human_col reaches 27 and stays 27, updating only at frame_start.
  - Stimulus: press both buttons.
  - Required: human_col does not change.
- Wrap (WRAP=1):
  - Stimulus: from 27, apply one right tick.
  - Required: human_col = 0 at the next frame.
  - Stimulus: apply one left tick.
  - Required: human_col = 27.
- Debounce and mode (DEB_LEN=3):
  - Stimulus: 2-cycle glitch on function_btn.
  - Required: mode unchanged.
  - Stimulus: clean press.
  - Required: mode = 1; screen_col = 0xFFFFFFFF on all rows; right_btn is ignored.
  - Stimulus: second press.
  - Required: mode = 0.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle with human_col=12, mode=1, r=7.
  - Required: the next cycle shows screen_row=1, screen_col=0, human_col=0, mode=0, frame_start=0.
